// File: rtl/dds_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_csr_pkg
// Description : Register offsets and bit positions shared by the DDS
//               multi-channel CSR block and its sample FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_csr_pkg;

    // Per-channel register offsets (Address[2:0])
    localparam logic [2:0] c_OFF_FCW    = 3'd0;
    localparam logic [2:0] c_OFF_CTRL   = 3'd1;
    localparam logic [2:0] c_OFF_THRESH = 3'd2;
    localparam logic [2:0] c_OFF_STATUS = 3'd3;
    localparam logic [2:0] c_OFF_SAMPLE = 3'd4;
    localparam logic [2:0] c_OFF_LEVEL  = 3'd5;

    // CTRL bits
    localparam int c_CTRL_RUN_BIT    = 0;
    localparam int c_CTRL_IRQ_EN_BIT = 1;
    localparam int c_CTRL_FLUSH_BIT  = 2;

    // STATUS bits (write-one-to-clear)
    localparam int c_STAT_PEND_BIT = 0;
    localparam int c_STAT_OVF_BIT  = 1;

    // SAMPLE read: marks that a real sample was popped
    localparam int c_SAMPLE_VALID_BIT = 31;

endpackage
`default_nettype wire

// File: rtl/csr_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : csr_sample_fifo
// Description : Per-channel sample FIFO. Push and pop may coincide even when
//               full; a push into a full FIFO without a pop is dropped and
//               reported. Flush empties it in one cycle and beats any push.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_sample_fifo #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_push,
    input  logic                            i_pop,
    input  logic                            i_flush,
    input  logic [DATA_W-1:0]               i_din,
    output logic [DATA_W-1:0]               o_head,
    output logic [$clog2(FIFO_DEPTH):0]     o_level,
    output logic [$clog2(FIFO_DEPTH):0]     o_level_nxt,
    output logic                            o_drop
);
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic [c_LVL_W-1:0] w_level_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Pointers wrap explicitly so non-binary-aligned behaviour is never implied
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_full    = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_pop_ok  = i_pop && !w_empty && !i_flush;
    // A pop in the same cycle frees the slot the push writes into
    assign w_push_ok = i_push && !i_flush && (!w_full || w_pop_ok);
    assign o_drop    = i_push && !i_flush && w_full && !w_pop_ok;

    assign o_head      = r_mem[r_rd_ptr];
    assign o_level     = r_level;
    assign o_level_nxt = w_level_nxt;

    // Occupancy after this edge; the CSR uses it to detect threshold crossings
    always_comb begin
        w_level_nxt = r_level;
        if (i_flush) begin
            w_level_nxt = '0;
        end else if (w_push_ok && !w_pop_ok) begin
            w_level_nxt = r_level + c_LVL_W'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_level_nxt = r_level - c_LVL_W'(1);
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_level <= w_level_nxt;
        end
    end

    // Sample storage; contents are don't-care once pointers are cleared
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/dds_multi_csr.sv
`default_nettype none
// ============================================================================
// Module      : dds_multi_csr
// Description : Avalon-MM CSR block for a multi-channel DDS. Per channel it
//               holds FCW/CTRL/THRESH/STATUS, buffers generator samples in a
//               FIFO readable through SAMPLE, and raises a combined irq.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_multi_csr
    import dds_csr_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FCW_W      = 16,
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         ChipSelect,
    input  logic                         Write,
    input  logic                         Read,
    input  logic [$clog2(NUM_CH)+2:0]    Address,
    input  logic [31:0]                  WriteData,
    output logic [31:0]                  ReadData,
    input  logic [NUM_CH-1:0]            sample_valid,
    input  logic [NUM_CH*DATA_W-1:0]     sample_data,
    output logic [NUM_CH-1:0]            run,
    output logic [NUM_CH*FCW_W-1:0]      fcw,
    output logic                         irq
);
    localparam int c_CH_W  = $clog2(NUM_CH);
    localparam int c_IDX_W = (c_CH_W > 0) ? c_CH_W : 1;
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]          w_off;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_wr;
    logic                w_rd;
    logic [NUM_CH-1:0]   w_sel;
    logic [NUM_CH-1:0]   w_irq_src;
    logic [31:0]         w_rdv [NUM_CH];
    logic [31:0]         w_rd_mux;
    logic                w_unused_wdata;

    assign w_off          = Address[2:0];
    assign w_wr           = ChipSelect & Write;
    assign w_rd           = ChipSelect & Read;
    assign w_unused_wdata = ^WriteData;

    // Channel index from upper address bits; a single channel has none
    generate
        if (c_CH_W > 0) begin : g_idx
            assign w_idx = Address[c_CH_W+2:3];
        end else begin : g_idx_none
            assign w_idx = '0;
        end
    endgenerate

    // Out-of-range indices match no channel: writes vanish, reads return 0
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [FCW_W-1:0]   r_fcw;
        logic               r_run;
        logic               r_irq_en;
        logic               r_pend;
        logic               r_ovf;
        logic [c_LVL_W-1:0] r_thresh;
        logic [c_LVL_W-1:0] w_level;
        logic [c_LVL_W-1:0] w_level_nxt;
        logic [DATA_W-1:0]  w_head;
        logic [31:0]        w_rdv_c;
        logic               w_wr_ch;
        logic               w_push;
        logic               w_pop;
        logic               w_flush;
        logic               w_drop;
        logic               w_pend_set;
        logic               w_clr_pend;
        logic               w_clr_ovf;

        assign w_sel[c]    = (w_idx == c_IDX_W'(c));
        assign w_wr_ch     = w_wr && w_sel[c];
        assign w_flush     = w_wr_ch && (w_off == c_OFF_CTRL) && WriteData[c_CTRL_FLUSH_BIT];
        assign w_pop       = w_rd && w_sel[c] && (w_off == c_OFF_SAMPLE);
        assign w_push      = sample_valid[c] && r_run;
        assign w_clr_pend  = w_wr_ch && (w_off == c_OFF_STATUS) && WriteData[c_STAT_PEND_BIT];
        assign w_clr_ovf   = w_wr_ch && (w_off == c_OFF_STATUS) && WriteData[c_STAT_OVF_BIT];
        // Rising crossing of the threshold; THRESH=0 disables the event
        assign w_pend_set  = (r_thresh != '0) && (w_level < r_thresh) && (w_level_nxt >= r_thresh);

        assign run[c]                  = r_run;
        assign fcw[c*FCW_W +: FCW_W]   = r_fcw;
        assign w_irq_src[c]            = r_irq_en && (r_pend || r_ovf);
        assign w_rdv[c]                = w_rdv_c;

        csr_sample_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (Clk),
            .rst         (Reset),
            .i_push      (w_push),
            .i_pop       (w_pop),
            .i_flush     (w_flush),
            .i_din       (sample_data[c*DATA_W +: DATA_W]),
            .o_head      (w_head),
            .o_level     (w_level),
            .o_level_nxt (w_level_nxt),
            .o_drop      (w_drop)
        );

        // Register file writes; status sets override a simultaneous W1C
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_fcw    <= '0;
                r_run    <= 1'b0;
                r_irq_en <= 1'b0;
                r_thresh <= '0;
                r_pend   <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_wr_ch) begin
                    case (w_off)
                        c_OFF_FCW: r_fcw <= WriteData[FCW_W-1:0];
                        c_OFF_CTRL: begin
                            r_run    <= WriteData[c_CTRL_RUN_BIT];
                            r_irq_en <= WriteData[c_CTRL_IRQ_EN_BIT];
                        end
                        c_OFF_THRESH: r_thresh <= WriteData[c_LVL_W-1:0];
                        default: ;
                    endcase
                end
                r_pend <= (r_pend && !w_clr_pend) || w_pend_set;
                r_ovf  <= (r_ovf && !w_clr_ovf) || w_drop;
            end
        end

        // Read value of this channel's register at the current offset
        always_comb begin
            w_rdv_c = '0;
            case (w_off)
                c_OFF_FCW:    w_rdv_c = 32'(r_fcw);
                c_OFF_CTRL: begin
                    w_rdv_c[c_CTRL_RUN_BIT]    = r_run;
                    w_rdv_c[c_CTRL_IRQ_EN_BIT] = r_irq_en;
                end
                c_OFF_THRESH: w_rdv_c = 32'(r_thresh);
                c_OFF_STATUS: begin
                    w_rdv_c[c_STAT_PEND_BIT] = r_pend;
                    w_rdv_c[c_STAT_OVF_BIT]  = r_ovf;
                end
                c_OFF_SAMPLE: begin
                    if (w_level != '0) begin
                        w_rdv_c                     = 32'(w_head);
                        w_rdv_c[c_SAMPLE_VALID_BIT] = 1'b1;
                    end
                end
                c_OFF_LEVEL:  w_rdv_c = 32'(w_level);
                default: ;
            endcase
        end
    end

    // Select the addressed channel's read value
    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel[c]) w_rd_mux = w_rdv[c];
        end
    end

    // Registered read data (one-cycle latency) and combined interrupt
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ReadData <= '0;
            irq      <= 1'b0;
        end else begin
            if (w_rd) ReadData <= w_rd_mux;
            irq <= |w_irq_src;
        end
    end

endmodule
`default_nettype wire
